// File: rtl/tdc_pattern_gen.sv
// Thermometer pattern generator for TDC delay-line calibration: drives a single
// 0->1 edge at a chosen tap, either once or swept over a range of positions.
module tdc_pattern_gen #(
    parameter  int NUM_DSP_PER_LINE = 16,
    localparam int LINE_W           = NUM_DSP_PER_LINE * 48
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic              i_abort,
    input  logic [15:0]       i_pos_start,
    input  logic [15:0]       i_pos_end,
    input  logic [7:0]        i_hold,
    output logic [LINE_W-1:0] o_dout,
    output logic              o_valid,
    output logic [15:0]       o_pos,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [15:0] POS_MIN = 16'd2;
    localparam logic [15:0] POS_MAX = 16'(LINE_W - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRIVE = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic              r_mode;
    logic [15:0]       r_pos_cur;
    logic [15:0]       r_pos_end;
    logic [7:0]        r_hold;
    logic [7:0]        r_hold_cnt;

    logic [LINE_W-1:0] r_dout;
    logic [15:0]       r_pos;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_start_ok;
    logic [15:0]       w_pos_inc;
    state_t            w_step_next;
    logic [LINE_W-1:0] w_therm;

    logic [LINE_W-1:0] w_dout_next;
    logic [15:0]       w_pos_next;
    logic              w_valid_next;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_err_next;

    // Sweep end only matters in sweep mode; single mode ignores i_pos_end entirely.
    assign w_start_ok = (i_pos_start >= POS_MIN) && (i_pos_start <= POS_MAX) &&
                        (!i_mode || ((i_pos_start <= i_pos_end) && (i_pos_end <= POS_MAX)));

    assign w_pos_inc   = r_pos_cur + 16'd1;
    assign w_step_next = (r_mode && (w_pos_inc <= r_pos_end)) ? S_DRIVE : S_DONE;

    genvar gi;
    generate
        for (gi = 0; gi < LINE_W; gi++) begin : g_therm
            assign w_therm[gi] = (16'(gi) >= r_pos_cur);
        end
    endgenerate

    // State and run-context registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_pos_cur  <= 16'd0;
            r_pos_end  <= 16'd0;
            r_hold     <= 8'd0;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (i_abort) begin
                r_hold_cnt <= 8'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && w_start_ok) begin
                            r_mode    <= i_mode;
                            r_pos_cur <= i_pos_start;
                            r_pos_end <= i_pos_end;
                            r_hold    <= i_hold;
                        end
                    end
                    S_DRIVE: begin
                        if (r_hold == 8'd0) begin
                            r_pos_cur <= w_pos_inc;
                        end else begin
                            r_hold_cnt <= r_hold;
                        end
                    end
                    S_HOLD: begin
                        if (r_hold_cnt <= 8'd1) begin
                            r_pos_cur  <= w_pos_inc;
                            r_hold_cnt <= 8'd0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (i_abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && w_start_ok) begin
                        w_state_next = S_LOAD;
                    end
                end
                S_LOAD:  w_state_next = S_DRIVE;
                S_DRIVE: w_state_next = (r_hold == 8'd0) ? w_step_next : S_HOLD;
                S_HOLD:  w_state_next = (r_hold_cnt <= 8'd1) ? w_step_next : S_HOLD;
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Output decode; results are registered so the pattern lands one edge after DRIVE.
    always_comb begin
        w_dout_next  = r_dout;
        w_pos_next   = r_pos;
        w_valid_next = 1'b0;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        if (i_abort) begin
            w_dout_next = '0;
            w_pos_next  = 16'd0;
            w_busy_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_dout_next = '0;
                    w_pos_next  = 16'd0;
                    w_busy_next = i_start && w_start_ok;
                    w_err_next  = i_start && !w_start_ok;
                end
                S_LOAD: begin
                    w_busy_next = 1'b1;
                end
                S_DRIVE: begin
                    w_dout_next  = w_therm;
                    w_pos_next   = r_pos_cur;
                    w_valid_next = 1'b1;
                    w_busy_next  = 1'b1;
                end
                S_HOLD: begin
                    w_busy_next = 1'b1;
                end
                S_DONE: begin
                    w_dout_next = '0;
                    w_pos_next  = 16'd0;
                    w_busy_next = 1'b0;
                    w_done_next = 1'b1;
                end
                default: begin
                    w_dout_next = '0;
                    w_pos_next  = 16'd0;
                    w_busy_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dout  <= '0;
            r_pos   <= 16'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_dout  <= w_dout_next;
            r_pos   <= w_pos_next;
            r_valid <= w_valid_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
        end
    end

    assign o_dout  = r_dout;
    assign o_pos   = r_pos;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_err   = r_err;

endmodule

// File: tb/tb_tdc_pattern_gen.sv
// Scoreboard bench for tdc_pattern_gen: expected positions are queued at command
// time and compared against each o_valid pattern; directed code checks timing.
module tb_tdc_pattern_gen;

    localparam int W = 768;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_mode = 1'b0;
    logic          i_abort = 1'b0;
    logic [15:0]   i_pos_start = 16'd0;
    logic [15:0]   i_pos_end = 16'd0;
    logic [7:0]    i_hold = 8'd0;
    logic [W-1:0]  o_dout;
    logic          o_valid;
    logic [15:0]   o_pos;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    int n_checks = 0;
    int n_err = 0;
    int valid_cnt = 0;
    int done_cnt = 0;
    int patt_cnt = 0;
    int cyc = 0;
    int exp_q[$];
    logic [W-1:0] exp_cur = '0;

    tdc_pattern_gen #(.NUM_DSP_PER_LINE(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
        .i_abort(i_abort), .i_pos_start(i_pos_start), .i_pos_end(i_pos_end),
        .i_hold(i_hold), .o_dout(o_dout), .o_valid(o_valid), .o_pos(o_pos),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] therm(input int p);
        logic [W-1:0] r;
        for (int j = 0; j < W; j++) r[j] = (j >= p);
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic mode, input logic [15:0] ps, input logic [15:0] pe,
                        input logic [7:0] hd);
        i_mode = mode; i_pos_start = ps; i_pos_end = pe; i_hold = hd;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit got = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (o_done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("done_seen", W'(got), W'(1));
    endtask

    // Scoreboard monitor: pops one expected position per o_valid and tracks the
    // pattern that o_dout must show on every cycle.
    always @(negedge clk) begin
        int p;
        cyc++;
        if (o_valid) begin
            valid_cnt++;
            check("exp_q_nonempty", W'(exp_q.size() > 0), W'(1));
            if (exp_q.size() > 0) begin
                p = exp_q.pop_front();
                exp_cur = therm(p);
                check("valid_pos", W'(o_pos), W'(p));
                $display("cycle %0d: pattern pos=%0d expected=%0d", cyc, o_pos, p);
            end
        end else if (!o_busy) begin
            exp_cur = '0;
        end
        check("dout", o_dout, exp_cur);
        if (o_done) done_cnt++;
        if (o_busy && (o_dout != '0)) patt_cnt++;
    end

    initial begin
        int v0, d0, p0;
        logic [15:0] bad_ps[3];
        logic [15:0] bad_pe[3];
        logic        bad_md[3];
        bad_ps = '{16'd1, 16'd767, 16'd50};
        bad_pe = '{16'd0, 16'd0, 16'd40};
        bad_md = '{1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (3) tick();
        check("rst_dout", o_dout, '0);
        check("rst_flags", W'({o_valid, o_busy, o_done, o_err}), W'(0));
        check("rst_pos", W'(o_pos), W'(0));
        rst_n = 1'b1;
        tick();

        // Single position 100, hold 0: exact latency
        exp_q.push_back(100);
        d0 = done_cnt;
        send(1'b0, 16'd100, 16'd0, 8'd0);
        check("single_busy_t", W'(o_busy), W'(1));
        check("single_valid_t", W'(o_valid), W'(0));
        tick();
        check("single_valid_t1", W'(o_valid), W'(0));
        tick();
        check("single_valid_t2", W'(o_valid), W'(1));
        check("single_pos", W'(o_pos), W'(100));
        check("single_dout", o_dout, therm(100));
        tick();
        check("single_done", W'(o_done), W'(1));
        check("single_busy_end", W'(o_busy), W'(0));
        check("single_dout_end", o_dout, '0);
        tick();
        check("single_done_pulse", W'(o_done), W'(0));
        check("single_done_cnt", W'(done_cnt - d0), W'(1));

        // Sweep 2..5, hold 0: four back-to-back patterns
        v0 = valid_cnt; d0 = done_cnt; p0 = patt_cnt;
        for (int p = 2; p <= 5; p++) exp_q.push_back(p);
        send(1'b1, 16'd2, 16'd5, 8'd0);
        wait_done(20);
        tick();
        check("sweep_valids", W'(valid_cnt - v0), W'(4));
        check("sweep_patt_cycles", W'(patt_cnt - p0), W'(4));
        check("sweep_done_cnt", W'(done_cnt - d0), W'(1));

        // Sweep 10..12, hold 3: each step held 4 cycles
        v0 = valid_cnt; d0 = done_cnt; p0 = patt_cnt;
        for (int p = 10; p <= 12; p++) exp_q.push_back(p);
        send(1'b1, 16'd10, 16'd12, 8'd3);
        wait_done(40);
        tick();
        check("hold_valids", W'(valid_cnt - v0), W'(3));
        check("hold_patt_cycles", W'(patt_cnt - p0), W'(12));
        check("hold_done_cnt", W'(done_cnt - d0), W'(1));

        // Rejected commands
        for (int k = 0; k < 3; k++) begin
            send(bad_md[k], bad_ps[k], bad_pe[k], 8'd0);
            check("err_pulse", W'(o_err), W'(1));
            check("err_busy", W'(o_busy), W'(0));
            check("err_dout", o_dout, '0);
            tick();
            check("err_pulse_end", W'(o_err), W'(0));
            check("err_busy_after", W'(o_busy), W'(0));
        end

        // Sweep 20..40 hold 2, stray start mid-run, abort after third pattern
        v0 = valid_cnt; d0 = done_cnt;
        for (int p = 20; p <= 40; p++) exp_q.push_back(p);
        send(1'b1, 16'd20, 16'd40, 8'd2);
        repeat (2) tick();
        send(1'b0, 16'd300, 16'd0, 8'd0);
        check("stray_start_no_err", W'(o_err), W'(0));
        for (int i = 0; i < 30 && (valid_cnt - v0) < 3; i++) tick();
        check("abort_reach_step3", W'(valid_cnt - v0), W'(3));
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_busy", W'(o_busy), W'(0));
        check("abort_dout", o_dout, '0);
        check("abort_valid", W'(o_valid), W'(0));
        repeat (8) tick();
        check("abort_no_done", W'(done_cnt - d0), W'(0));
        check("abort_no_more_valid", W'(valid_cnt - v0), W'(3));
        exp_q.delete();

        // Reset mid-sweep at hold 255, then single run at 766
        v0 = valid_cnt;
        for (int p = 100; p <= 200; p++) exp_q.push_back(p);
        send(1'b1, 16'd100, 16'd200, 8'd255);
        for (int i = 0; i < 10 && valid_cnt == v0; i++) tick();
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_dout", o_dout, '0);
        check("rst_mid_flags", W'({o_valid, o_busy, o_done, o_err}), W'(0));
        check("rst_mid_pos", W'(o_pos), W'(0));
        @(posedge clk);
        tick();
        exp_q.delete();
        exp_q.push_back(766);
        v0 = valid_cnt; d0 = done_cnt;
        rst_n = 1'b1;
        send(1'b0, 16'd766, 16'd0, 8'd0);
        check("post_rst_busy", W'(o_busy), W'(1));
        wait_done(10);
        tick();
        check("post_rst_valids", W'(valid_cnt - v0), W'(1));
        check("post_rst_done_cnt", W'(done_cnt - d0), W'(1));
        check("post_rst_q_empty", W'(exp_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
